// File: rtl/game_ctl.sv
// Air-hockey match sequencer: goal detection, scoring and
// ball freeze/re-centre/release control, one step per frame.
module game_ctl #(
  parameter int LEFT_GOAL_X  = 30,
  parameter int RIGHT_GOAL_X = 993,
  parameter int GOAL_Y_MIN   = 284,
  parameter int GOAL_Y_MAX   = 484,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int GOAL_FRAMES  = 90
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        btn_start,
  input  logic [11:0] xpos_ball,
  input  logic [11:0] ypos_ball,
  output logic        ball_en,
  output logic        ball_rst,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic [1:0]  winner,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    GOAL  = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [11:0] LX   = 12'(LEFT_GOAL_X);
  localparam logic [11:0] RX   = 12'(RIGHT_GOAL_X);
  localparam logic [11:0] YMIN = 12'(GOAL_Y_MIN);
  localparam logic [11:0] YMAX = 12'(GOAL_Y_MAX);
  localparam logic [3:0]  WIN  = 4'(WIN_SCORE);
  localparam logic [7:0]  S_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]  G_LAST = 8'(GOAL_FRAMES - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] p1_n, p2_n;
  logic [1:0] win_n;
  logic       brst_n;
  logic       vblnk_q, btn_q;
  logic       tick, start_evt;
  logic       in_mouth, goal_l, goal_r;

  assign tick      = vblnk_in & ~vblnk_q;
  assign start_evt = btn_start & ~btn_q;
  assign in_mouth  = (ypos_ball >= YMIN) && (ypos_ball <= YMAX);
  assign goal_l    = in_mouth && (xpos_ball <= LX);
  assign goal_r    = in_mouth && (xpos_ball >= RX);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p1_n    = score_p1;
    p2_n    = score_p2;
    win_n   = winner;
    brst_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start_evt) begin
          state_n = SERVE;
          cnt_n   = 8'd0;
          brst_n  = 1'b1;
        end
      end
      SERVE: begin
        if (tick) begin
          if (cnt == S_LAST) begin
            state_n = PLAY;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      PLAY: begin
        // left goal takes precedence if both decode true
        if (tick && goal_l) begin
          p2_n    = (score_p2 == 4'hF) ? score_p2 : score_p2 + 4'd1;
          state_n = GOAL;
          cnt_n   = 8'd0;
        end else if (tick && goal_r) begin
          p1_n    = (score_p1 == 4'hF) ? score_p1 : score_p1 + 4'd1;
          state_n = GOAL;
          cnt_n   = 8'd0;
        end
      end
      GOAL: begin
        if (tick) begin
          if (cnt == G_LAST) begin
            cnt_n = 8'd0;
            if (score_p1 == WIN) begin
              state_n = OVER;
              win_n   = 2'b01;
            end else if (score_p2 == WIN) begin
              state_n = OVER;
              win_n   = 2'b10;
            end else begin
              state_n = SERVE;
              brst_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      OVER: begin
        if (start_evt) begin
          p1_n    = 4'd0;
          p2_n    = 4'd0;
          win_n   = 2'b00;
          state_n = SERVE;
          cnt_n   = 8'd0;
          brst_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      score_p1  <= 4'd0;
      score_p2  <= 4'd0;
      winner    <= 2'b00;
      ball_rst  <= 1'b0;
      ball_en   <= 1'b0;
      state_out <= 3'd0;
      vblnk_q   <= 1'b1;
      btn_q     <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      score_p1  <= p1_n;
      score_p2  <= p2_n;
      winner    <= win_n;
      ball_rst  <= brst_n;
      ball_en   <= (state == PLAY);
      state_out <= state;
      vblnk_q   <= vblnk_in;
      btn_q     <= btn_start;
    end
  end

endmodule
